atomic_count_reader: RTL and testbench

Initiator side of the 32-bit atomic counter read interface. On a start command it issues the two-request sequence that reads a 64-bit event counter over the 32-bit request/acknowledge bus:
- first request with atomic asserted, returning bits [31:0];
- second request without atomic, returning bits [63:32].

It captures both halves, checks the one-cycle acknowledge rule, and presents the assembled 64-bit value plus the delta since the previous completed read. It sits between a host/sampling agent and any atomic counter responder in the SoC.

---
 rtl/atomic_cnt_pkg.sv | 14 +
 rtl/atomic_count_reader.sv | 112 +++++++++++
 tb/tb_atomic_count_reader.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/atomic_cnt_pkg.sv
// Shared definitions for the atomic 64-bit counter read protocol (initiator and responder sides).
package atomic_cnt_pkg;

    localparam int BUS_W = 32;
    localparam int CNT_W = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LO    = 2'd1,
        HI    = 2'd2,
        FLUSH = 2'd3
    } state_e;

endpackage

// File: rtl/atomic_count_reader.sv
// Initiator for the two-request atomic counter read: low half with atomic set, then high half.
// Assembles the 64-bit value, reports the delta since the last read, and polices the 1-cycle ack.
module atomic_count_reader
    import atomic_cnt_pkg::*;
#(
    parameter int CHECK_ACK = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             rd_start_i,
    output logic             rd_busy_o,
    output logic             rd_valid_o,
    output logic [CNT_W-1:0] rd_data_o,
    output logic [CNT_W-1:0] rd_delta_o,
    output logic             rd_err_o,
    output logic             req_o,
    output logic             atomic_o,
    input  logic             ack_i,
    input  logic [BUS_W-1:0] count_i
);

    state_e           state_q, state_d;
    logic             pending_q, pending_d;
    logic             exp_ack_q, exp_lo_q;
    logic [BUS_W-1:0] lo_q;
    logic             req_d, atomic_d, busy_d;
    logic             chk_en, err_miss, err_spur, take, cap_lo, cap_hi, start_any;
    logic [CNT_W-1:0] new_val;

    // Ack classification; FLUSH swallows whatever the aborted request returns.
    always_comb begin
        chk_en    = (CHECK_ACK != 0) && (state_q != FLUSH);
        err_miss  = chk_en && exp_ack_q && !ack_i;
        err_spur  = chk_en && !exp_ack_q && ack_i;
        take      = exp_ack_q && (state_q != FLUSH) && (ack_i || (CHECK_ACK == 0));
        cap_lo    = take && exp_lo_q;
        cap_hi    = take && !exp_lo_q;
        start_any = rd_start_i || pending_q;
        new_val   = {count_i, lo_q};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            req_o     <= 1'b0;
            atomic_o  <= 1'b0;
            rd_busy_o <= 1'b0;
            exp_ack_q <= 1'b0;
            exp_lo_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            req_o     <= req_d;
            atomic_o  <= atomic_d;
            rd_busy_o <= busy_d;
            exp_ack_q <= req_o;
            exp_lo_q  <= atomic_o;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = start_any ? LO : IDLE;
            LO:      state_d = HI;
            HI:      state_d = start_any ? LO : IDLE;
            FLUSH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (err_miss) begin
            state_d = FLUSH;
        end

        // Starts seen while LO or FLUSH cannot launch immediately, so remember one.
        pending_d = pending_q;
        if (err_miss) begin
            pending_d = 1'b0;
        end else if (rd_start_i && (state_q == LO || state_q == FLUSH)) begin
            pending_d = 1'b1;
        end else if (state_d == LO) begin
            pending_d = 1'b0;
        end
    end

    always_comb begin
        req_d    = (state_d == LO) || (state_d == HI);
        atomic_d = (state_d == LO);
        busy_d   = (state_d != IDLE) || pending_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lo_q       <= '0;
            rd_data_o  <= '0;
            rd_delta_o <= '0;
            rd_valid_o <= 1'b0;
            rd_err_o   <= 1'b0;
        end else begin
            rd_valid_o <= cap_hi;
            rd_err_o   <= err_miss || err_spur;
            if (cap_lo) begin
                lo_q <= count_i;
            end
            if (cap_hi) begin
                rd_data_o  <= new_val;
                rd_delta_o <= new_val - rd_data_o;
            end
        end
    end

endmodule

// File: tb/tb_atomic_count_reader.sv
// Bench for atomic_count_reader: behavioural responder with a live counter and a queue-based read model.
module tb_atomic_count_reader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rd_start_i;
    logic        ack_i;
    logic [31:0] count_i;

    logic        rd_busy_o, rd_valid_o, rd_err_o, req_o, atomic_o;
    logic [63:0] rd_data_o, rd_delta_o;
    logic        nc_busy, nc_valid, nc_err, nc_req, nc_atomic;
    logic [63:0] nc_data, nc_delta;

    atomic_count_reader #(.CHECK_ACK(1)) dut (
        .clk(clk), .reset_n(reset_n), .rd_start_i(rd_start_i),
        .rd_busy_o(rd_busy_o), .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o),
        .rd_delta_o(rd_delta_o), .rd_err_o(rd_err_o), .req_o(req_o),
        .atomic_o(atomic_o), .ack_i(ack_i), .count_i(count_i)
    );

    atomic_count_reader #(.CHECK_ACK(0)) dut_nc (
        .clk(clk), .reset_n(reset_n), .rd_start_i(rd_start_i),
        .rd_busy_o(nc_busy), .rd_valid_o(nc_valid), .rd_data_o(nc_data),
        .rd_delta_o(nc_delta), .rd_err_o(nc_err), .req_o(nc_req),
        .atomic_o(nc_atomic), .ack_i(ack_i), .count_i(count_i)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [63:0] cnt;
    logic [31:0] snap;
    bit          live, drop_hi, spur;
    logic [63:0] exp_q[$];
    logic [63:0] prev_m;
    int          nvalid, nerr, nerr_nc;
    logic        prev_req_atomic;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: responder answers last cycle's request, then outputs are observed.
    task automatic step();
        logic        r, a;
        logic [63:0] e;
        r = req_o;
        a = atomic_o;
        @(posedge clk);
        #1;
        ack_i   = 1'b0;
        count_i = $urandom;
        if (r) begin
            if (a) begin
                count_i = cnt[31:0];
                snap    = cnt[63:32];
                ack_i   = 1'b1;
                exp_q.push_back(cnt);
            end else if (drop_hi) begin
                drop_hi = 1'b0;
                if (exp_q.size() > 0) void'(exp_q.pop_back());
            end else begin
                count_i = snap;
                ack_i   = 1'b1;
            end
        end else if (spur) begin
            spur  = 1'b0;
            ack_i = 1'b1;
        end
        if (live) cnt = cnt + 64'd1;

        if (rd_valid_o) begin
            if (exp_q.size() == 0) begin
                chk("valid_unexpected", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rd_data", rd_data_o, e);
                chk("rd_delta", rd_delta_o, e - prev_m);
                prev_m = e;
            end
            nvalid++;
        end
        if (rd_err_o) nerr++;
        if (nc_err) nerr_nc++;
        if (atomic_o && !req_o) chk("atomic_without_req", 64'd1, 64'd0);
        if (req_o) begin
            if (atomic_o && prev_req_atomic) chk("atomic_twice", 64'd1, 64'd0);
            prev_req_atomic = atomic_o;
        end
    endtask

    task automatic single_read(input logic [63:0] val);
        cnt        = val;
        live       = 1'b0;
        rd_start_i = 1'b1;
        step();
        rd_start_i = 1'b0;
        repeat (5) step();
    endtask

    initial begin
        int          v0, e0, ne;
        logic [63:0] hold;
        int          vcyc[$];

        reset_n = 1'b0; rd_start_i = 1'b0; ack_i = 1'b0; count_i = '0;
        cnt = '0; snap = '0; live = 0; drop_hi = 0; spur = 0;
        prev_m = '0; nvalid = 0; nerr = 0; nerr_nc = 0; prev_req_atomic = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_req", req_o, 0);
        chk("reset_busy", rd_busy_o, 0);
        chk("reset_data", rd_data_o, 0);
        chk("reset_delta", rd_delta_o, 0);
        chk("reset_valid_err", {rd_valid_o, rd_err_o, atomic_o}, 0);
        reset_n = 1'b1;
        step();

        // Single read with per-cycle timing checks.
        cnt = 64'h0000_0001_DEAD_BEEF; live = 0;
        rd_start_i = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            step();
            rd_start_i = 1'b0;
            chk("single_req", req_o, (c == 1 || c == 2));
            chk("single_atomic", atomic_o, (c == 1));
            chk("single_busy", rd_busy_o, (c == 1 || c == 2));
            chk("single_valid", rd_valid_o, (c == 4));
            if (c == 4) begin
                chk("single_data", rd_data_o, 64'h0000_0001_DEAD_BEEF);
                chk("single_delta", rd_delta_o, 64'h0000_0001_DEAD_BEEF);
            end
        end

        // Back-to-back reads against a live counter crossing the lo/hi carry.
        cnt = 64'h0000_0001_FFFF_FFFC; live = 1;
        v0 = nvalid;
        for (int k = 0; k < 10; k++) begin
            rd_start_i = (k < 5);
            step();
            if (k + 1 <= 6) begin
                chk("burst_req", req_o, 1);
                chk("burst_atomic", atomic_o, ((k + 1) % 2 == 1));
            end
            if (rd_valid_o) begin
                if (vcyc.size() > 0) begin
                    chk("burst_delta", rd_delta_o, 64'd2);
                    chk("burst_spacing", k + 1 - vcyc[vcyc.size()-1], 2);
                end
                vcyc.push_back(k + 1);
            end
        end
        chk("burst_count", nvalid - v0, 3);
        live = 0;

        // Delta wraps through 2^64.
        single_read(64'hFFFF_FFFF_FFFF_FFFE);
        single_read(64'h0000_0000_0000_0003);
        chk("wrap_delta", rd_delta_o, 64'd5);

        // Missing high-half ack aborts the read through FLUSH.
        hold = rd_data_o; v0 = nvalid; e0 = nerr;
        drop_hi = 1; rd_start_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            rd_start_i = 1'b0;
            if (rd_err_o) begin
                chk("flush_busy", rd_busy_o, 1);
                chk("flush_req", req_o, 0);
            end
        end
        chk("miss_err_count", nerr - e0, 1);
        chk("miss_no_valid", nvalid - v0, 0);
        chk("miss_data_hold", rd_data_o, hold);
        chk("miss_back_idle", rd_busy_o, 0);
        v0 = nvalid;
        single_read(64'h1234_5678_9ABC_DEF0);
        chk("after_miss_valid", nvalid - v0, 1);
        chk("after_miss_data", rd_data_o, 64'h1234_5678_9ABC_DEF0);

        // Spurious ack while idle.
        hold = rd_data_o; e0 = nerr; ne = nerr_nc;
        spur = 1;
        repeat (3) step();
        chk("spur_err", nerr - e0, 1);
        chk("spur_err_nocheck", nerr_nc - ne, 0);
        chk("spur_data_hold", rd_data_o, hold);

        // Asynchronous reset in the middle of a read.
        cnt = 64'hCAFE_F00D_0BAD_BEEF; live = 0;
        rd_start_i = 1'b1;
        step();
        rd_start_i = 1'b0;
        step();
        reset_n = 1'b0;
        #1;
        chk("midrst_req", {req_o, atomic_o}, 0);
        chk("midrst_ctrl", {rd_busy_o, rd_valid_o, rd_err_o}, 0);
        chk("midrst_data", rd_data_o, 0);
        chk("midrst_delta", rd_delta_o, 0);
        exp_q.delete(); prev_m = '0; ack_i = 1'b0; prev_req_atomic = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        v0 = nvalid;
        single_read(64'h0000_0042_8000_0001);
        chk("post_rst_valid", nvalid - v0, 1);
        chk("post_rst_delta", rd_delta_o, 64'h0000_0042_8000_0001);

        // Randomized starts against a counter with occasional jumps.
        e0 = nerr; live = 1;
        for (int k = 0; k < 400; k++) begin
            rd_start_i = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) cnt = {$urandom, $urandom};
            step();
        end
        rd_start_i = 1'b0;
        repeat (10) step();
        chk("rand_drained", exp_q.size(), 0);
        chk("rand_no_err", nerr - e0, 0);
        chk("rand_idle", rd_busy_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
